// File: rtl/instr_byte_gather.sv
`default_nettype none
// ============================================================================
//  Module      : instr_byte_gather
//  Description : Fetch-path front end. Issues 1-3 sequential single-byte
//                reads on a fixed-latency byte-wide memory port and assembles
//                them into a 24-bit instruction window for the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_byte_gather #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    // fetch request
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_len_i,
    input  logic              flush_i,
    // assembled window
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [23:0]       resp_data_o,
    output logic [ADDR_W-1:0] resp_addr_o,
    // byte-wide memory port
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic [7:0]        mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [1:0]         r_len;
    logic [1:0]         r_idx;
    logic [23:0]        r_data;
    logic               r_req_ready;
    logic               r_mem_req;
    logic               r_resp_valid;

    logic [1:0]         w_len_eff;
    logic [1:0]         w_idx_next;
    logic               w_more;
    logic [ADDR_W-1:0]  w_next_addr;

    // A length of zero is treated as a single-byte fetch.
    assign w_len_eff   = (req_len_i == 2'd0) ? 2'd1 : req_len_i;
    assign w_idx_next  = r_idx + 2'd1;
    assign w_more      = (w_idx_next < r_len);
    // Address of the next byte; wraps naturally modulo 2^ADDR_W.
    assign w_next_addr = r_addr + ADDR_W'(w_idx_next);

    assign req_ready_o  = r_req_ready;
    assign mem_req_o    = r_mem_req;
    assign mem_addr_o   = r_mem_addr;
    assign resp_valid_o = r_resp_valid;
    assign resp_data_o  = r_data;
    assign resp_addr_o  = r_addr;

    // Request sequencer: state, byte index, data lanes and registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_mem_addr   <= '0;
            r_len        <= 2'd1;
            r_idx        <= 2'd0;
            r_data       <= 24'd0;
            r_req_ready  <= 1'b0;
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b0;
        end else if (flush_i) begin
            // Abort wins over everything; a byte granted this cycle returns
            // next cycle but is ignored because we are back in IDLE.
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_state     <= S_REQ;
                        r_addr      <= req_addr_i;
                        r_mem_addr  <= req_addr_i;
                        r_len       <= w_len_eff;
                        r_idx       <= 2'd0;
                        r_data      <= 24'd0;
                        r_req_ready <= 1'b0;
                        r_mem_req   <= 1'b1;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        r_state   <= S_WAIT;
                        r_mem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    case (r_idx)
                        2'd0:    r_data[7:0]   <= mem_rdata_i;
                        2'd1:    r_data[15:8]  <= mem_rdata_i;
                        default: r_data[23:16] <= mem_rdata_i;
                    endcase
                    r_idx <= w_idx_next;
                    if (w_more) begin
                        r_state    <= S_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_next_addr;
                    end else begin
                        r_state      <= S_DONE;
                        r_resp_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (resp_ready_i) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_mem_req    <= 1'b0;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_byte_gather.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_byte_gather
//  Description : Self-checking bench for instr_byte_gather: table of fetch
//                vectors plus hand-written reset and flush sequences, with a
//                response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_byte_gather;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic [15:0] req_addr_i = '0;
    logic [1:0]  req_len_i = '0;
    logic        flush_i = 1'b0;
    logic        resp_ready_i = 1'b0;
    logic        mem_gnt_i = 1'b0;
    logic [7:0]  mem_rdata_i = '0;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic [23:0] resp_data_o;
    logic [15:0] resp_addr_o;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [0:65535];
    logic [39:0] sb[$];
    logic [39:0] exp_e;

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  len;
        logic [7:0]  b0, b1, b2;
        logic [23:0] exp;
        int          lat;
        int          stall_byte;
        int          stall;
        int          bp;
    } vec_t;

    vec_t vecs[6];

    instr_byte_gather #(.ADDR_W(16)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_len_i    (req_len_i),
        .flush_i      (flush_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_addr_o  (resp_addr_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Fixed-latency memory: data one cycle after grant.
    always @(posedge clk) begin
        if (mem_req_o && mem_gnt_i)
            mem_rdata_i <= mem[mem_addr_o];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare every accepted response against the queued expectation.
    always @(negedge clk) begin
        if (rstn_i && resp_valid_o && resp_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got data 0x%0h expected no response", resp_data_o);
            end else begin
                exp_e = sb.pop_front();
                chk("resp_data", {8'd0, resp_data_o}, {8'd0, exp_e[39:16]});
                chk("resp_addr", {16'd0, resp_addr_o}, {16'd0, exp_e[15:0]});
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int cyc, nreq, stall_left, bp_left, leff;
        bit seen, done;
        logic [15:0] a;
        a = v.addr;         mem[a] = v.b0;
        a = a + 16'd1;      mem[a] = v.b1;
        a = a + 16'd1;      mem[a] = v.b2;
        leff = (v.len == 2'd0) ? 1 : int'(v.len);
        for (int w = 0; w < 10 && !req_ready_o; w++) tick();
        chk({tag, " req_ready"}, {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        req_addr_i  = v.addr;
        req_len_i   = v.len;
        sb.push_back({v.exp, v.addr});
        tick();
        req_valid_i = 1'b0;
        cyc = 1; nreq = 0; stall_left = v.stall; bp_left = v.bp; seen = 0; done = 0;
        while (!done && cyc < 40) begin
            mem_gnt_i    = 1'b0;
            resp_ready_i = 1'b0;
            if (mem_req_o) begin
                chk({tag, " mem_addr"}, {16'd0, mem_addr_o}, {16'd0, v.addr + 16'(nreq)});
                if (nreq == v.stall_byte && stall_left > 0) begin
                    stall_left--;
                end else begin
                    if (v.stall == 0)
                        chk({tag, " req_cycle"}, cyc, 1 + 2 * nreq);
                    mem_gnt_i = 1'b1;
                    nreq++;
                end
            end
            if (resp_valid_o) begin
                if (!seen) begin
                    chk({tag, " resp_cycle"}, cyc, v.lat);
                    seen = 1;
                end
                chk({tag, " ready_in_done"}, {31'd0, req_ready_o}, 32'd0);
                chk({tag, " held_data"}, {8'd0, resp_data_o}, {8'd0, v.exp});
                if (bp_left > 0) bp_left--;
                else begin
                    resp_ready_i = 1'b1;
                    done = 1;
                end
            end
            tick();
            cyc++;
        end
        resp_ready_i = 1'b0;
        mem_gnt_i    = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no response within 40 cycles expected 0x%0h", tag, v.exp);
        end
        chk({tag, " mem_req_count"}, nreq, leff);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        vec_t fv;
        //         addr      len   b0     b1     b2     exp          lat sb  st bp
        vecs[0] = '{16'h8000, 2'd1, 8'hA9, 8'hEE, 8'hDD, 24'h0000A9, 3,  0,  0, 0};
        vecs[1] = '{16'hFFFE, 2'd3, 8'h4C, 8'h34, 8'h12, 24'h12344C, 7,  0,  0, 0};
        vecs[2] = '{16'h1234, 2'd2, 8'h11, 8'h22, 8'h33, 24'h002211, 8,  1,  3, 4};
        vecs[3] = '{16'h0100, 2'd0, 8'h77, 8'h88, 8'h99, 24'h000077, 3,  0,  0, 0};
        vecs[4] = '{16'h4000, 2'd2, 8'h5A, 8'hC3, 8'hF0, 24'h00C35A, 6,  0,  1, 0};
        vecs[5] = '{16'h00FF, 2'd3, 8'h01, 8'h02, 8'h03, 24'h030201, 7,  0,  0, 1};

        // Power-on reset values.
        #12;
        chk("rst req_ready", {31'd0, req_ready_o}, 32'd0);
        chk("rst mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("rst resp_data", {8'd0, resp_data_o}, 32'd0);
        chk("rst mem_addr", {16'd0, mem_addr_o}, 32'd0);
        rstn_i = 1'b1;
        tick();
        chk("post_rst req_ready", {31'd0, req_ready_o}, 32'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted while byte 0 of a len-3 fetch is returning.
        mem[16'h2000] = 8'h31;
        req_valid_i = 1'b1; req_addr_i = 16'h2000; req_len_i = 2'd3;
        sb.push_back({24'h000031, 16'h2000});
        tick();
        req_valid_i = 1'b0;
        chk("rstw mem_req N+1", {31'd0, mem_req_o}, 32'd1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk("rstw in_wait", {31'd0, mem_req_o}, 32'd0);
        #2 rstn_i = 1'b0;
        #1;
        chk("rstw async req_ready", {31'd0, req_ready_o}, 32'd0);
        chk("rstw async resp_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("rstw async resp_data", {8'd0, resp_data_o}, 32'd0);
        chk("rstw async resp_addr", {16'd0, resp_addr_o}, 32'd0);
        chk("rstw async mem_addr", {16'd0, mem_addr_o}, 32'd0);
        void'(sb.pop_back());
        tick(); tick();
        #2 rstn_i = 1'b1;
        tick();
        chk("rstw release req_ready", {31'd0, req_ready_o}, 32'd1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid_o || mem_req_o) bad = 1;
            tick();
        end
        chk("rstw no_activity", {31'd0, bad}, 32'd0);

        // Flush during the WAIT of byte 1 of a len-3 fetch.
        mem[16'h3000] = 8'h91; mem[16'h3001] = 8'h92; mem[16'h3002] = 8'h93;
        req_valid_i = 1'b1; req_addr_i = 16'h3000; req_len_i = 2'd3;
        sb.push_back({24'h939291, 16'h3000});
        tick();
        req_valid_i = 1'b0;
        chk("flush mem_req b0", {31'd0, mem_req_o}, 32'd1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        tick();
        chk("flush mem_addr b1", {16'd0, mem_addr_o}, 32'h3001);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        void'(sb.pop_back());
        chk("flush idle req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("flush mem_req", {31'd0, mem_req_o}, 32'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid_o) bad = 1;
            tick();
        end
        chk("flush no_resp", {31'd0, bad}, 32'd0);

        // Request coinciding with flush in IDLE must be dropped.
        flush_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 16'h3200; req_len_i = 2'd1;
        tick();
        flush_i = 1'b0; req_valid_i = 1'b0;
        chk("flush_idle req_ready", {31'd0, req_ready_o}, 32'd1);
        tick();
        chk("flush_idle mem_req", {31'd0, mem_req_o}, 32'd0);

        fv = '{16'h3100, 2'd1, 8'h5E, 8'hA1, 8'hA2, 24'h00005E, 3, 0, 0, 0};
        run_vec(fv, "after_flush");

        tick(); tick();
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_byte_gather.md
# instr_byte_gather

Memory-side front end of the CPU fetch path. It takes a start address and a byte count (1-3) and performs sequential single-byte reads on a byte-wide, fixed-latency memory port. It then assembles the bytes into the 24-bit window (opcode plus up to two operand bytes) that the CPU fetch stage consumes as `mem_data_i`. It sits between the program-memory/bus port and the CPU top.

## Interface
- `ADDR_W`, default 16: address width; address arithmetic wraps modulo 2^ADDR_W.
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  fetch request valid.
- `req_ready_o`  out  1  block can accept a request.
- `req_addr_i`  in  ADDR_W  address of first byte.
- `req_len_i`  in  2  number of bytes to read; 1, 2 or 3 (0 treated as 1).
- `flush_i`  in  1  abort current request; no response is produced.
- `resp_valid_o`  out  1  assembled window valid.
- `resp_ready_i`  in  1  consumer accepts window.
- `resp_data_o`  out  24  `[7:0]` = byte at addr, `[15:8]` = addr+1, `[23:16]` = addr+2; unread bytes 0.
- `resp_addr_o`  out  ADDR_W  start address of the returned window.
- `mem_req_o`  out  1  memory read request.
- `mem_addr_o`  out  ADDR_W  memory byte address.
- `mem_gnt_i`  in  1  memory accepted request this cycle.
- `mem_rdata_i`  in  8  read data, valid exactly one cycle after grant.

## Operation
- States:
  - IDLE: `req_ready_o`=1.
  - REQ: `mem_req_o`=1.
  - WAIT: read data returning.
  - DONE: `resp_valid_o`=1.
- Transitions:
  - IDLE -> REQ on `req_valid_i`. At that edge, latch addr, len (0 -> 1) and a byte index of 0; clear the data register.
  - REQ holds while `!mem_gnt_i`. `mem_addr_o` = latched addr + index (mod 2^ADDR_W), stable while held. On `mem_gnt_i` -> WAIT.
  - WAIT: capture `mem_rdata_i` into byte lane `[index]` and increment index. Go to REQ if index+1 < len, else DONE.
  - DONE holds `resp_data_o`/`resp_addr_o` stable until `resp_ready_i`; then -> IDLE.
- `flush_i` has priority over all other transitions. Any state goes to IDLE next cycle, and no `resp_valid_o` is produced for the aborted request.
  - A grant given in the flush cycle is still honoured by memory; the returning byte is ignored.
  - A request presented in the same cycle as `flush_i` while in IDLE is not accepted.
- `req_ready_o` is asserted only in IDLE, so there is one request outstanding at most.
- Outputs are registered state decodes or registers: `req_ready_o`, `mem_req_o`, `resp_valid_o` and the data/address registers.
- Reset (any time, including mid-request) forces IDLE immediately.
  - Reset values: `req_ready_o`=0 while `rstn_i`=0 and 1 after release (IDLE decode); `mem_req_o`=0; `resp_valid_o`=0; `resp_data_o`=0; `resp_addr_o`=0; `mem_addr_o`=0; index=0.
  - Outside REQ, `mem_addr_o` holds its last value.

## Timing
- Accept in cycle N (`req_valid_i` && `req_ready_o`, no flush).
- With `mem_gnt_i` held at 1:
  - byte k is requested in cycle N+1+2k;
  - byte k's data is sampled at the end of cycle N+2+2k;
  - `resp_valid_o` rises in cycle N+2·len+1 (len 1 -> N+3, len 3 -> N+7).
- Each cycle of `mem_gnt_i`=0 in REQ adds exactly one cycle.
- If `resp_ready_i`=1 in the first DONE cycle, the response lasts one cycle. IDLE is reached the next cycle, and the next request is accepted in that cycle at the earliest (one idle cycle minimum between requests).
- Address wrap: start 0xFFFE, len 3 reads 0xFFFE, 0xFFFF, 0x0000.

## Test plan
- Reset: assert `rstn_i`=0 mid-WAIT. Required: outputs go to reset values asynchronously; after release `req_ready_o`=1; no response appears.
- Single-byte fetch: addr 0x8000, len 1, `mem_gnt_i`=1, memory returns 0xA9. Required: `mem_req_o` in N+1 with addr 0x8000; `resp_valid_o` in N+3 with data 0x0000A9 and `resp_addr_o` 0x8000.
- Three-byte fetch with wrap: addr 0xFFFE, len 3, memory bytes 0x4C, 0x34, 0x12. Required: addresses 0xFFFE, 0xFFFF, 0x0000 in N+1, N+3, N+5; `resp_data_o` 0x12344C in N+7.
- Grant stall and response backpressure: len 2, `mem_gnt_i` low for 3 cycles on byte 1, `resp_ready_i` low for 4 cycles.
  - Required during the stall: `mem_addr_o` stable; `resp_valid_o` in N+8.
  - Required during backpressure: data held stable while `resp_ready_i` is low, and `req_ready_o`=0 throughout.
- Flush: assert `flush_i` in the WAIT of byte 1 of a len-3 request. Required: IDLE next cycle, no `resp_valid_o`. A following len-1 request returns the correct byte, not stale lanes (upper bytes 0).
- len 0: addr 0x0100, len 0. Required: behaves as len 1, with exactly one memory request.
